// File: rtl/axilm_pkg.sv
// Shared definitions for the two-requester AXI4-Lite master arbiter.
package axilm_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WADDR = 3'd1,
      WRESP = 3'd2,
      RADDR = 3'd3,
      RDATA = 3'd4
   } axilm_state_t;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
   localparam logic [2:0] PROT_DEFAULT  = 3'b000;
   localparam logic [3:0] WSTRB_ALL     = 4'b1111;

endpackage

// File: rtl/axilm_rr2.sv
// Two-way round-robin grant: a lone request always wins, a tie goes to ptr.
module axilm_rr2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = ptr ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/axilm_arb2.sv
// Arbitrates two simple request/ack clients onto one AXI4-Lite master port.
// Optional watchdog: define AXILM_ARB_WDOG_EN to abort stuck transfers after TO_CYCLES.
//
// state | meaning
// IDLE  | no transfer outstanding; round-robin grant when no ack is pulsing
// WADDR | AW and W channels driven until each has handshaken
// WRESP | BREADY high, waiting for BVALID
// RADDR | ARVALID high, waiting for ARREADY
// RDATA | RREADY high, waiting for RVALID
module axilm_arb2
   import axilm_pkg::*;
#(
   parameter logic [3:0] CACHE_VAL = 4'b0011,
   parameter int         TO_CYCLES = 1023
) (
   input  logic        ACLK,
   input  logic        ARESETN,

   input  logic        R0_REQ,
   input  logic        R0_WE,
   input  logic [31:0] R0_ADDR,
   input  logic [31:0] R0_WDATA,
   output logic        R0_ACK,
   output logic [31:0] R0_RDATA,
   output logic        R0_ERR,

   input  logic        R1_REQ,
   input  logic        R1_WE,
   input  logic [31:0] R1_ADDR,
   input  logic [31:0] R1_WDATA,
   output logic        R1_ACK,
   output logic [31:0] R1_RDATA,
   output logic        R1_ERR,

   output logic        AXI_AWVALID,
   input  logic        AXI_AWREADY,
   output logic [31:0] AXI_AWADDR,
   output logic [2:0]  AXI_AWPROT,
   output logic [3:0]  AXI_AWCACHE,

   output logic        AXI_WVALID,
   input  logic        AXI_WREADY,
   output logic [31:0] AXI_WDATA,
   output logic [3:0]  AXI_WSTRB,

   input  logic        AXI_BVALID,
   output logic        AXI_BREADY,
   input  logic [1:0]  AXI_BRESP,

   output logic        AXI_ARVALID,
   input  logic        AXI_ARREADY,
   output logic [31:0] AXI_ARADDR,
   output logic [2:0]  AXI_ARPROT,
   output logic [3:0]  AXI_ARCACHE,

   input  logic        AXI_RVALID,
   output logic        AXI_RREADY,
   input  logic [31:0] AXI_RDATA,
   input  logic [1:0]  AXI_RRESP
);

   if (TO_CYCLES < 1) begin : g_bad_to
      $error("axilm_arb2: TO_CYCLES must be at least 1");
   end

   axilm_state_t state, state_n;
   logic        ptr, ptr_n;
   logic        owner, owner_n;
   logic [31:0] addr_q, addr_n;
   logic [31:0] wdata_q, wdata_n;
   logic        aw_done, aw_done_n;
   logic        w_done, w_done_n;
   logic [1:0]  ack_q, ack_n;
   logic        err_q, err_n;
   logic [31:0] rdata_q, rdata_n;

   logic [1:0]  gnt;
   logic        we_sel;
   logic        aw_hs;
   logic        w_hs;
   logic        done;
   logic        done_err;
   logic [31:0] done_rdata;
   logic        wd_tc;

   axilm_rr2 u_rr2 (
      .req (  {R1_REQ, R0_REQ}),
      .ptr (ptr),
      .gnt (gnt)
   );

   assign we_sel = gnt[1] ? R1_WE : R0_WE;
   assign aw_hs  = AXI_AWVALID & AXI_AWREADY;
   assign w_hs   = AXI_WVALID & AXI_WREADY;

`ifdef AXILM_ARB_WDOG_EN
   // Loaded with TO_CYCLES-1 while idle so the TO_CYCLES-th busy cycle hits zero.
   localparam int WD_W = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TO_CYCLES - 1);

   logic [WD_W-1:0] wd_cnt;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wd_cnt <= '0;
      end else if (state == IDLE) begin
         wd_cnt <= WD_LOAD;
      end else if (wd_cnt != '0) begin
         wd_cnt <= wd_cnt - 1'b1;
      end
   end

   assign wd_tc = (state != IDLE) && (wd_cnt == '0);
`else
   assign wd_tc = 1'b0;
`endif

   always_comb begin
      state_n    = state;
      ptr_n      = ptr;
      owner_n    = owner;
      addr_n     = addr_q;
      wdata_n    = wdata_q;
      aw_done_n  = aw_done;
      w_done_n   = w_done;
      ack_n      = 2'b00;
      err_n      = 1'b0;
      rdata_n    = 32'd0;
      done       = 1'b0;
      done_err   = 1'b0;
      done_rdata = 32'd0;

      case (state)
         IDLE: begin
            // Holding off while ack pulses keeps the just-served client from re-winning.
            if ((ack_q == 2'b00) && (gnt != 2'b00)) begin
               owner_n   = gnt[1];
               ptr_n     = ~gnt[1];
               addr_n    = gnt[1] ? R1_ADDR : R0_ADDR;
               wdata_n   = gnt[1] ? R1_WDATA : R0_WDATA;
               aw_done_n = 1'b0;
               w_done_n  = 1'b0;
               state_n   = we_sel ? WADDR : RADDR;
            end
         end
         WADDR: begin
            aw_done_n = aw_done | aw_hs;
            w_done_n  = w_done | w_hs;
            if (aw_done_n && w_done_n) begin
               state_n = WRESP;
            end
         end
         WRESP: begin
            if (AXI_BVALID) begin
               done     = 1'b1;
               done_err = (AXI_BRESP != AXI_RESP_OKAY);
            end
         end
         RADDR: begin
            if (AXI_ARREADY) begin
               state_n = RDATA;
            end
         end
         RDATA: begin
            if (AXI_RVALID) begin
               done       = 1'b1;
               done_err   = (AXI_RRESP != AXI_RESP_OKAY);
               done_rdata = AXI_RDATA;
            end
         end
         default: state_n = IDLE;
      endcase

      // A real completion in the same cycle as the timeout takes precedence.
      if (wd_tc && !done) begin
         done       = 1'b1;
         done_err   = 1'b1;
         done_rdata = 32'd0;
      end

      if (done) begin
         state_n   = IDLE;
         aw_done_n = 1'b0;
         w_done_n  = 1'b0;
         ack_n     = owner ? 2'b10 : 2'b01;
         err_n     = done_err;
         rdata_n   = done_rdata;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state   <= IDLE;
         ptr     <= 1'b0;
         owner   <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         ack_q   <= 2'b00;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         state   <= state_n;
         ptr     <= ptr_n;
         owner   <= owner_n;
         addr_q  <= addr_n;
         wdata_q <= wdata_n;
         aw_done <= aw_done_n;
         w_done  <= w_done_n;
         ack_q   <= ack_n;
         err_q   <= err_n;
         rdata_q <= rdata_n;
      end
   end

   assign AXI_AWVALID = (state == WADDR) && !aw_done;
   assign AXI_WVALID  = (state == WADDR) && !w_done;
   assign AXI_AWADDR  = AXI_AWVALID ? addr_q : 32'd0;
   assign AXI_WDATA   = AXI_WVALID ? wdata_q : 32'd0;
   assign AXI_WSTRB   = AXI_WVALID ? WSTRB_ALL : 4'b0000;
   assign AXI_BREADY  = (state == WRESP);
   assign AXI_ARVALID = (state == RADDR);
   assign AXI_ARADDR  = AXI_ARVALID ? addr_q : 32'd0;
   assign AXI_RREADY  = (state == RDATA);

   assign AXI_AWPROT  = PROT_DEFAULT;
   assign AXI_ARPROT  = PROT_DEFAULT;
   assign AXI_AWCACHE = (state != IDLE) ? CACHE_VAL : 4'b0000;
   assign AXI_ARCACHE = (state != IDLE) ? CACHE_VAL : 4'b0000;

   assign R0_ACK   = ack_q[0];
   assign R1_ACK   = ack_q[1];
   assign R0_ERR   = ack_q[0] & err_q;
   assign R1_ERR   = ack_q[1] & err_q;
   assign R0_RDATA = ack_q[0] ? rdata_q : 32'd0;
   assign R1_RDATA = ack_q[1] ? rdata_q : 32'd0;

endmodule

// File: tb/tb_axilm_arb2.sv
// Self-checking bench for axilm_arb2: transaction-level model plus directed scenarios.
module tb_axilm_arb2;

   localparam int TO = 15;

   logic ACLK = 1'b0;
   logic ARESETN;
   always #5 ACLK = ~ACLK;

   logic        r0_req, r0_we, r1_req, r1_we;
   logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
   logic        r0_ack, r0_err, r1_ack, r1_err;
   logic [31:0] r0_rdata, r1_rdata;

   logic        awvalid, wvalid, bready, arvalid, rready;
   logic [31:0] awaddr, wdata, araddr;
   logic [2:0]  awprot, arprot;
   logic [3:0]  awcache, arcache, wstrb;

   logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
   logic [1:0]  bresp = 2'b00, rresp = 2'b00;
   logic [31:0] rdata = 32'd0;

   axilm_arb2 #(.CACHE_VAL(4'b0011), .TO_CYCLES(TO)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .R0_REQ(r0_req), .R0_WE(r0_we), .R0_ADDR(r0_addr), .R0_WDATA(r0_wdata),
      .R0_ACK(r0_ack), .R0_RDATA(r0_rdata), .R0_ERR(r0_err),
      .R1_REQ(r1_req), .R1_WE(r1_we), .R1_ADDR(r1_addr), .R1_WDATA(r1_wdata),
      .R1_ACK(r1_ack), .R1_RDATA(r1_rdata), .R1_ERR(r1_err),
      .AXI_AWVALID(awvalid), .AXI_AWREADY(awready), .AXI_AWADDR(awaddr),
      .AXI_AWPROT(awprot), .AXI_AWCACHE(awcache),
      .AXI_WVALID(wvalid), .AXI_WREADY(wready), .AXI_WDATA(wdata), .AXI_WSTRB(wstrb),
      .AXI_BVALID(bvalid), .AXI_BREADY(bready), .AXI_BRESP(bresp),
      .AXI_ARVALID(arvalid), .AXI_ARREADY(arready), .AXI_ARADDR(araddr),
      .AXI_ARPROT(arprot), .AXI_ARCACHE(arcache),
      .AXI_RVALID(rvalid), .AXI_RREADY(rready), .AXI_RDATA(rdata), .AXI_RRESP(rresp)
   );

   wire [186:0] all_out = {r0_ack, r1_ack, r0_err, r1_err, r0_rdata, r1_rdata,
                           awvalid, awaddr, awprot, awcache, wvalid, wdata, wstrb,
                           bready, arvalid, araddr, arprot, arcache, rready};

   int n_pass = 0;
   int n_tot  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   int cyc = 0;
   always @(posedge ACLK) cyc++;

   // ---------------- slave model ----------------
   int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
   bit          b_never = 1'b0;
   logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
   logic [31:0] s_rdata = 32'd0;

   bit s_aw_hs, s_w_hs, s_b_hs, s_ar_hs, s_r_hs;
   always @(negedge ACLK) begin
      s_aw_hs = awvalid & awready;
      s_w_hs  = wvalid & wready;
      s_b_hs  = bvalid & bready;
      s_ar_hs = arvalid & arready;
      s_r_hs  = rvalid & rready;
   end

   int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
   bit aw_got = 0, w_got = 0, ar_got = 0;
   always @(posedge ACLK) begin
      #1;
      if (!ARESETN) begin
         awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
         bresp = 0; rresp = 0; rdata = 0;
         aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
         aw_got = 0; w_got = 0; ar_got = 0;
      end else begin
         if (s_aw_hs) aw_got = 1;
         if (s_w_hs)  w_got  = 1;
         if (s_ar_hs) ar_got = 1;
         if (s_b_hs) begin
            bvalid = 0; bresp = 0; aw_got = 0; w_got = 0; b_cnt = 0;
         end
         if (s_r_hs) begin
            rvalid = 0; rresp = 0; rdata = 0; ar_got = 0; r_cnt = 0;
         end
         aw_cnt  = awvalid ? aw_cnt + 1 : 0;
         w_cnt   = wvalid  ? w_cnt + 1  : 0;
         ar_cnt  = arvalid ? ar_cnt + 1 : 0;
         awready = awvalid && (aw_cnt > aw_wait);
         wready  = wvalid  && (w_cnt > w_wait);
         arready = arvalid && (ar_cnt > ar_wait);
         if (aw_got && w_got && !bvalid && !b_never) begin
            b_cnt++;
            if (b_cnt > b_wait) begin bvalid = 1; bresp = s_bresp; end
         end
         if (ar_got && !rvalid) begin
            r_cnt++;
            if (r_cnt > r_wait) begin rvalid = 1; rdata = s_rdata; rresp = s_rresp; end
         end
      end
   end

   // ---------------- transaction model and per-cycle compare ----------------
   bit          active = 0, ack_due = 0, timed_out = 0;
   int          exp_owner = 0, ptr_m = 0;
   bit          exp_we = 0, exp_err = 0;
   logic [31:0] exp_addr = 0, exp_wdata = 0, exp_rdata = 0;
   int          aw_n, w_n, b_n, ar_n, r_n, act_cycles;
   int          grant_cyc = 0, last_ack_cyc = -10, last_lat = -1;
   logic [1:0]  prev_req = 2'b00;
   logic        prev_we [2];
   logic [31:0] prev_addr [2];
   logic [31:0] prev_wdata [2];
   int          grant_log[$];

   always @(negedge ACLK) begin
      if (!ARESETN) begin
         chk("reset_outputs_zero", 64'(|all_out), 64'd0);
         active = 0; ack_due = 0; ptr_m = 0; prev_req = 2'b00;
         last_ack_cyc = -10;
         grant_log.delete();
      end else begin
         if (ack_due) begin
            chk("ack_vector", 64'({r1_ack, r0_ack}), 64'(exp_owner == 1 ? 2'b10 : 2'b01));
            chk("ack_err", 64'(exp_owner == 1 ? r1_err : r0_err), 64'(exp_err));
            chk("ack_rdata", 64'(exp_owner == 1 ? r1_rdata : r0_rdata), 64'(exp_rdata));
            if (!timed_out && exp_we) begin
               chk("aw_handshakes", 64'(aw_n), 64'd1);
               chk("w_handshakes", 64'(w_n), 64'd1);
               chk("b_handshakes", 64'(b_n), 64'd1);
            end else if (!timed_out) begin
               chk("ar_handshakes", 64'(ar_n), 64'd1);
               chk("r_handshakes", 64'(r_n), 64'd1);
            end
            last_lat = cyc - grant_cyc;
            last_ack_cyc = cyc;
            active = 0; ack_due = 0;
         end else begin
            chk("ack_spurious", 64'({r1_ack, r0_ack}), 64'd0);
         end
         if (r0_ack | r1_ack)
            chk("valid_during_ack", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);

         if (!active && (awvalid | wvalid | arvalid)) begin
            int w;
            grant_cyc = cyc - 1;
            chk("grant_had_request", 64'(prev_req != 2'b00), 64'd1);
            chk("grant_in_ack_cycle", 64'(grant_cyc == last_ack_cyc), 64'd0);
            case (prev_req)
               2'b01:   w = 0;
               2'b10:   w = 1;
               2'b11:   w = ptr_m;
               default: w = 0;
            endcase
            ptr_m = 1 - w;
            grant_log.push_back(w);
            exp_owner = w; exp_we = prev_we[w];
            exp_addr = prev_addr[w]; exp_wdata = prev_wdata[w];
            active = 1; timed_out = 0; act_cycles = 0;
            aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
            chk("start_valids", 64'({awvalid, wvalid, arvalid}), 64'(exp_we ? 3'b110 : 3'b001));
         end else if (active) begin
            if (aw_n > 0) chk("awvalid_dropped", 64'(awvalid), 64'd0);
            if (w_n > 0)  chk("wvalid_dropped", 64'(wvalid), 64'd0);
            if (ar_n > 0) chk("arvalid_dropped", 64'(arvalid), 64'd0);
         end

         chk("idle_bus_zero", 64'((awvalid ? 32'd0 : awaddr) | (wvalid ? 32'd0 : wdata) |
                                  (arvalid ? 32'd0 : araddr)), 64'd0);
         chk("wstrb", 64'(wstrb), 64'(wvalid ? 4'hF : 4'h0));
         chk("prot", 64'({awprot, arprot}), 64'd0);
         chk("cache", 64'({awcache, arcache}), 64'(active ? 8'h33 : 8'h00));
         if (bready) chk("bready_context", 64'({active, exp_we}), 64'd3);
         if (rready) chk("rready_context", 64'({active, exp_we}), 64'd2);

         if (active) begin
            act_cycles++;
            if (awvalid && awready) begin aw_n++; chk("awaddr", 64'(awaddr), 64'(exp_addr)); end
            if (wvalid && wready)   begin w_n++;  chk("wdata", 64'(wdata), 64'(exp_wdata)); end
            if (arvalid && arready) begin ar_n++; chk("araddr", 64'(araddr), 64'(exp_addr)); end
            if (bvalid && bready) begin
               b_n++; ack_due = 1; exp_err = (bresp != 2'b00); exp_rdata = 0;
            end
            if (rvalid && rready) begin
               r_n++; ack_due = 1; exp_err = (rresp != 2'b00); exp_rdata = rdata;
            end
`ifdef AXILM_ARB_WDOG_EN
            if (!ack_due && act_cycles == TO) begin
               ack_due = 1; exp_err = 1; exp_rdata = 0; timed_out = 1;
            end
`endif
         end

         prev_req = {r1_req, r0_req};
         prev_we[0] = r0_we; prev_addr[0] = r0_addr; prev_wdata[0] = r0_wdata;
         prev_we[1] = r1_we; prev_addr[1] = r1_addr; prev_wdata[1] = r1_wdata;
      end
   end

   function automatic int winner_at(input int idx);
      return (idx < grant_log.size()) ? grant_log[idx] : -1;
   endfunction

   // ---------------- stimulus ----------------
   task automatic do_req(input int n, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, output logic err, output logic [31:0] rd);
      int k;
      @(posedge ACLK); #1;
      if (n == 0) begin r0_we = we; r0_addr = addr; r0_wdata = wd; r0_req = 1; end
      else        begin r1_we = we; r1_addr = addr; r1_wdata = wd; r1_req = 1; end
      err = 0; rd = 0;
      for (k = 0; k < 200; k++) begin
         @(negedge ACLK);
         if ((n == 0) ? r0_ack : r1_ack) break;
      end
      chk($sformatf("req%0d_ack_timeout", n), 64'(k < 200), 64'd1);
      err = (n == 0) ? r0_err : r1_err;
      rd  = (n == 0) ? r0_rdata : r1_rdata;
      @(posedge ACLK); #1;
      if (n == 0) r0_req = 0; else r1_req = 0;
   endtask

   task automatic apply_reset();
      @(posedge ACLK); #1;
      ARESETN = 0;
      repeat (3) @(posedge ACLK);
      #1;
      ARESETN = 1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      logic        e0, e1;
      logic [31:0] d0, d1;
      int          k;
      ARESETN = 0;
      r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
      r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
      repeat (3) @(posedge ACLK);
      #1;
      chk("reset_hold_outputs", 64'(|all_out), 64'd0);
      ARESETN = 1;

      // zero-wait write from R0
      do_req(0, 1'b1, 32'h0000_0010, 32'h1234_5678, e0, d0);
      chk("wr_latency", 64'(last_lat), 64'd3);
      chk("wr_err", 64'(e0), 64'd0);
      chk("wr_winner", 64'(winner_at(0)), 64'd0);

      // contention from reset, then R1 alone
      apply_reset();
      s_rdata = 32'h0000_AAAA;
      fork
         do_req(0, 1'b0, 32'h0000_0100, 32'd0, e0, d0);
         do_req(1, 1'b0, 32'h0000_0200, 32'd0, e1, d1);
      join
      chk("contend_first", 64'(winner_at(0)), 64'd0);
      chk("contend_second", 64'(winner_at(1)), 64'd1);
      chk("contend_r1_rdata", 64'(d1), 64'h0000_AAAA);
      do_req(1, 1'b0, 32'h0000_0204, 32'd0, e1, d1);
      chk("rerequest_winner", 64'(winner_at(2)), 64'd1);
      chk("read_latency", 64'(last_lat), 64'd3);

      // AWREADY two cycles ahead of WREADY
      w_wait = 2;
      fork
         do_req(0, 1'b1, 32'h0000_0044, 32'h0000_55AA, e0, d0);
         begin
            for (k = 0; k < 50; k++) begin
               @(negedge ACLK);
               if (awvalid && awready) break;
            end
            @(negedge ACLK);
            chk("skew_aw_drop_w_hold", 64'({awvalid, wvalid}), 64'b01);
         end
      join
      chk("skew_latency", 64'(last_lat), 64'd5);
      w_wait = 0;

      // read error on R1
      s_rresp = 2'b10; s_rdata = 32'hDEAD_BEEF;
      do_req(1, 1'b0, 32'h0000_0300, 32'd0, e1, d1);
      chk("rderr_rdata", 64'(d1), 64'hDEAD_BEEF);
      chk("rderr_err", 64'(e1), 64'd1);
      s_rresp = 2'b00;

      // reset while waiting in WRESP
      b_wait = 30;
      @(posedge ACLK); #1;
      r0_we = 1; r0_addr = 32'h0000_0040; r0_wdata = 32'h0000_CAFE; r0_req = 1;
      for (k = 0; k < 50; k++) begin
         @(negedge ACLK);
         if (bready) break;
      end
      chk("reached_wresp", 64'(k < 50), 64'd1);
      @(posedge ACLK); #2;
      ARESETN = 0;
      #1;
      chk("reset_async_zero", 64'(|all_out), 64'd0);
      r0_req = 0;
      repeat (2) @(posedge ACLK);
      #1;
      ARESETN = 1;
      b_wait = 0;
      fork
         do_req(0, 1'b0, 32'h0000_0500, 32'd0, e0, d0);
         do_req(1, 1'b0, 32'h0000_0600, 32'd0, e1, d1);
      join
      chk("post_reset_winner", 64'(winner_at(0)), 64'd0);

`ifdef AXILM_ARB_WDOG_EN
      apply_reset();
      b_never = 1;
      do_req(0, 1'b1, 32'h0000_0080, 32'h0000_0001, e0, d0);
      chk("wdog_err", 64'(e0), 64'd1);
      chk("wdog_rdata", 64'(d0), 64'd0);
      chk("wdog_latency", 64'(last_lat), 64'(TO + 1));
      @(negedge ACLK);
      chk("wdog_valids_low", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
      b_never = 0;
      apply_reset();
`endif

      repeat (3) @(posedge ACLK);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/axilm_arb2.md
AXILM_ARB2 -- requirements
Module: axilm_arb2

Interface
REQ-001 Parameter CACHE_VAL, default 4'b0011, SHALL drive AXI_AWCACHE/AXI_ARCACHE while a request is outstanding.
REQ-002 Parameter TO_CYCLES, default 1023, SHALL set the watchdog limit in ACLK cycles (see REQ-030).
REQ-003 ACLK  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 ARESETN  input  1  reset, asynchronous assert, active-low.
REQ-005 Rn_REQ  input  1  requester n (n=0,1) SHALL hold it high, with other Rn_* inputs stable, until Rn_ACK.
REQ-006 Rn_WE  input  1  1=write, 0=read.
REQ-007 Rn_ADDR  input  32  byte address.
REQ-008 Rn_WDATA  input  32  write data; WSTRB SHALL be 4'b1111.
REQ-009 Rn_ACK  output  1  one-cycle pulse on completion.
REQ-010 Rn_RDATA  output  32  read data, valid with Rn_ACK.
REQ-011 Rn_ERR  output  1  valid with Rn_ACK; 1 when BRESP/RRESP != 2'b00 or watchdog fired.
REQ-012 AXI_AW*/W*/B*/AR*/R*  AXI4-Lite master ports, 32-bit addr/data; AXPROT SHALL be 3'b000.

Function
REQ-013 States: IDLE, WADDR, WRESP, RADDR, RDATA.
REQ-014 IDLE: grant SHALL be round-robin; pointer SHALL start at 0 and move past the winner after each grant.
REQ-015 Simultaneous R0_REQ and R1_REQ SHALL be resolved by the pointer; a lone request SHALL win regardless of the pointer.
REQ-016 Grant SHALL latch the winner's WE/ADDR/WDATA into registers; the next state SHALL be WADDR (WE=1) or RADDR (WE=0).
REQ-017 WADDR: AWVALID and WVALID SHALL assert together on the cycle after the grant.
REQ-018 Each of AWVALID and WVALID SHALL deassert independently on the cycle after its READY is sampled high.
REQ-019 AWVALID and WVALID SHALL NOT depend combinationally on READY.
REQ-020 WRESP SHALL be entered once both handshakes are done; BREADY SHALL be high in WRESP only.
REQ-021 When BVALID is sampled in WRESP: Rn_ACK SHALL pulse next cycle, ERR=(BRESP!=0), and the state SHALL return to IDLE.
REQ-022 RADDR: ARVALID SHALL assert until ARREADY is sampled; then RDATA.
REQ-023 RDATA: RREADY SHALL be high; on RVALID, RDATA SHALL be captured, Rn_ACK pulses, and the state SHALL return to IDLE.
REQ-024 Minimum latency with zero-wait slave: grant to Rn_ACK = 3 cycles for read, 3 for write.
REQ-025 A new grant SHALL NOT occur in the cycle Rn_ACK is high; at most one transaction SHALL be outstanding.
REQ-026 Rn_REQ dropping mid-transaction SHALL NOT abort the AXI transfer; Rn_ACK is still issued.
REQ-027 Unused address/data outputs SHALL be driven to 0 when the matching VALID is low.

Reset
REQ-028 ARESETN low SHALL force IDLE, pointer=0, and all VALID/READY/ACK/ERR outputs and all data/addr outputs to 0, including mid-transaction.
REQ-029 Reset release SHALL take effect on the first ACLK edge with ARESETN high; there SHALL be no pending grant.

Configuration
REQ-030 With AXILM_ARB_WDOG_EN defined: a counter SHALL run in every non-IDLE state; reaching TO_CYCLES SHALL drop all VALID/READY, pulse Rn_ACK with Rn_ERR=1, RDATA=0, and return to IDLE.
REQ-031 Without AXILM_ARB_WDOG_EN: no counter SHALL exist; TO_CYCLES SHALL be ignored and the block SHALL wait indefinitely.

Structure
REQ-032 Shared package axilm_pkg SHALL hold the state enum, AXI_RESP_OKAY=2'b00, PROT_DEFAULT=3'b000, and WSTRB_ALL=4'b1111.
REQ-033 The round-robin grant SHALL be a sub-module axilm_rr2 (inputs req[1:0], ptr; output gnt[1:0]); all else SHALL stay in one module.

Verification
REQ-034 Write test: R0 writes 0x1234_5678 to 0x0000_0010 with a zero-wait slave -> one AW and one W handshake, BREADY, R0_ACK 3 cycles after grant, R0_ERR=0.
REQ-035 Contention test: R0 and R1 both request reads from reset -> R0 granted first, R1 second; R1 then re-requests while R0 idle -> R1 granted.
REQ-036 Skewed write test: slave asserts AWREADY 2 cycles before WREADY -> AWVALID drops while WVALID holds; single BREADY handshake.
REQ-037 Read error test: R1 reads with RRESP=2'b10 and RDATA=0xDEAD_BEEF -> R1_RDATA=0xDEADBEEF, R1_ERR=1.
REQ-038 Reset test: ARESETN pulsed low during WRESP -> all outputs 0 immediately; the next request is granted to R0.
REQ-039 Watchdog test (WDOG_EN, TO_CYCLES=15): slave never asserts BVALID -> Rn_ACK with ERR=1 after 15 cycles; no VALID stays high.
